cond_flag_unit: RTL

Execute-stage condition/flag unit for the ARM-style pipeline: owns the architectural NZCV flag register. It evaluates each instruction's 4-bit condition field against the committed flags and gates that instruction's PC, register and memory writes. It also updates the flags from the ALU when the instruction executes. Registered write-enables feed the memory stage; the flag register feeds back into its own condition evaluation.

---
 rtl/cond_pkg.sv | 27 ++
 rtl/cond_eval.sv | 42 ++++
 rtl/cond_flag_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV flag bit positions for the
// execute-stage condition/flag unit.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic w_n, w_z, w_c, w_v, w_ge, w_hi, w_gt;

  assign w_n  = flags_i[FLAG_N];
  assign w_z  = flags_i[FLAG_Z];
  assign w_c  = flags_i[FLAG_C];
  assign w_v  = flags_i[FLAG_V];
  assign w_ge = (w_n == w_v);
  assign w_hi = w_c & ~w_z;
  assign w_gt = ~w_z & w_ge;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = w_z;
      COND_NE: cond_ex_o = ~w_z;
      COND_CS: cond_ex_o = w_c;
      COND_CC: cond_ex_o = ~w_c;
      COND_MI: cond_ex_o = w_n;
      COND_PL: cond_ex_o = ~w_n;
      COND_VS: cond_ex_o = w_v;
      COND_VC: cond_ex_o = ~w_v;
      COND_HI: cond_ex_o = w_hi;
      COND_LS: cond_ex_o = ~w_hi;
      COND_GE: cond_ex_o = w_ge;
      COND_LT: cond_ex_o = ~w_ge;
      COND_GT: cond_ex_o = w_gt;
      COND_LE: cond_ex_o = ~w_gt;
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Execute-stage condition/flag unit: owns NZCV, gates PC/reg/mem writes by the
// instruction condition and counts instructions squashed by a failed condition.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  output logic             cond_ex_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] skip_cnt_o
);

  logic [3:0]       r_flags;
  logic             r_pc_src, r_reg_write, r_mem_write;
  logic [CNT_W-1:0] r_skip_cnt;
  logic             w_cond_ex, w_adv, w_accept, w_fire, w_skip;

  cond_eval u_cond_eval (
    .cond_i    (cond_i),
    .flags_i   (r_flags),
    .cond_ex_o (w_cond_ex)
  );

  assign w_adv    = ~stall_i | flush_i;
  assign w_accept = valid_i & ~stall_i & ~flush_i;
  assign w_fire   = w_accept & w_cond_ex;
  assign w_skip   = w_accept & ~w_cond_ex;

  // Flags are evaluated against the registered value only; no ALU forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_fire) begin
      if (flag_w_i[1]) begin
        r_flags[FLAG_N] <= alu_flags_i[FLAG_N];
        r_flags[FLAG_Z] <= alu_flags_i[FLAG_Z];
      end
      if (flag_w_i[0]) begin
        r_flags[FLAG_C] <= alu_flags_i[FLAG_C];
        r_flags[FLAG_V] <= alu_flags_i[FLAG_V];
      end
    end
  end

  // Flush forces a bubble even when stalled; a plain stall holds the enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_src    <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_adv) begin
      if (flush_i || !valid_i) begin
        r_pc_src    <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_write <= 1'b0;
      end else begin
        r_pc_src    <= pcs_i & w_cond_ex;
        r_reg_write <= reg_w_i & w_cond_ex & ~no_write_i;
        r_mem_write <= mem_w_i & w_cond_ex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
    end else if (w_skip && (r_skip_cnt != '1)) begin
      r_skip_cnt <= r_skip_cnt + CNT_W'(1);
    end
  end

  assign cond_ex_o   = w_cond_ex;
  assign pc_src_o    = r_pc_src;
  assign reg_write_o = r_reg_write;
  assign mem_write_o = r_mem_write;
  assign flags_o     = r_flags;
  assign skip_cnt_o  = r_skip_cnt;

endmodule
